// File: rtl/hist_bank_reader_if.sv
// Port-B RAM access and clipped-histogram stream bundle for the CLAHE histogram reader.
interface hist_bank_reader_if #(
  parameter int unsigned NUM_BANKS = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned EXC_W     = 24
);
  logic                          start;
  logic [DATA_W-1:0]             clip_limit;
  logic                          portb_rd_flag;
  logic [ADDR_W-1:0]             portb_addr;
  logic [NUM_BANKS-1:0]          portb_wren_bus;
  logic [DATA_W-1:0]             portb_wdata;
  logic [NUM_BANKS*DATA_W-1:0]   portb_rdata;
  logic                          out_valid;
  logic [ADDR_W-1:0]             out_bin;
  logic [NUM_BANKS*DATA_W-1:0]   out_data;
  logic [NUM_BANKS*EXC_W-1:0]    exc_bus;
  logic                          busy;
  logic                          done;

  modport master (
    input  start, clip_limit, portb_rdata,
    output portb_rd_flag, portb_addr, portb_wren_bus, portb_wdata,
           out_valid, out_bin, out_data, exc_bus, busy, done
  );

  modport slave (
    output start, clip_limit, portb_rdata,
    input  portb_rd_flag, portb_addr, portb_wren_bus, portb_wdata,
           out_valid, out_bin, out_data, exc_bus, busy, done
  );
endinterface

// File: rtl/hist_bank_reader.sv
// Sweeps all histogram bins on port B, streams clipped per-bank counts and
// accumulates per-bank clip excess; optionally zeroes each bin as it is read.
module hist_bank_reader #(
  parameter int unsigned NUM_BANKS     = 32,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned RD_LAT        = 2,
  parameter int unsigned EXC_W         = 24,
  parameter bit          CLEAR_ON_READ = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  hist_bank_reader_if.master  bus
);

  localparam int unsigned NUM_BINS = 1 << ADDR_W;
  localparam logic [NUM_BANKS-1:0] WREN_MASK = CLEAR_ON_READ ? '1 : '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic                        rd_flag_q, rd_flag_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [NUM_BANKS-1:0]        wren_q;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [DATA_W-1:0]           clip_q, clip_d;
  logic                        exc_clr;
  logic                        last_out_c;

  logic [RD_LAT-1:0]           vpipe_q;
  logic [ADDR_W-1:0]           bpipe_q [RD_LAT];
  logic                        tail_v;
  logic                        out_valid_q;
  logic [ADDR_W-1:0]           out_bin_q;
  logic [NUM_BANKS*DATA_W-1:0] out_data_q;
  logic [NUM_BANKS*EXC_W-1:0]  exc_q;
  logic [NUM_BANKS*DATA_W-1:0] clip_data;
  logic [NUM_BANKS*EXC_W-1:0]  exc_sum;
  logic [DATA_W-1:0]           c;

  assign last_out_c = out_valid_q && (out_bin_q == ADDR_W'(NUM_BINS - 1));
  assign tail_v     = vpipe_q[RD_LAT-1];

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    rd_flag_d = 1'b0;
    addr_d    = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clip_d    = clip_q;
    exc_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_ISSUE;
          rd_flag_d = 1'b1;
          busy_d    = 1'b1;
          clip_d    = bus.clip_limit;
          exc_clr   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (addr_q == ADDR_W'(NUM_BINS - 1)) begin
          state_d = S_DRAIN;
        end else begin
          rd_flag_d = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (last_out_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_flag_q <= 1'b0;
      addr_q    <= '0;
      wren_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clip_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_flag_q <= rd_flag_d;
      addr_q    <= addr_d;
      wren_q    <= rd_flag_d ? WREN_MASK : '0;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clip_q    <= clip_d;
    end
  end

  // Tracks which issued address the returning read data belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) bpipe_q[i] <= '0;
    end else begin
      vpipe_q[0] <= rd_flag_q;
      bpipe_q[0] <= addr_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        bpipe_q[i] <= bpipe_q[i-1];
      end
    end
  end

  // Per-bank clip and excess
  always_comb begin
    clip_data = '0;
    exc_sum   = exc_q;
    c         = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      c = bus.portb_rdata[i*DATA_W +: DATA_W];
      if (c > clip_q) begin
        clip_data[i*DATA_W +: DATA_W] = clip_q;
        exc_sum[i*EXC_W +: EXC_W]     = exc_q[i*EXC_W +: EXC_W] + EXC_W'(c - clip_q);
      end else begin
        clip_data[i*DATA_W +: DATA_W] = c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_data_q  <= '0;
      exc_q       <= '0;
    end else begin
      out_valid_q <= tail_v;
      out_bin_q   <= tail_v ? bpipe_q[RD_LAT-1] : '0;
      out_data_q  <= tail_v ? clip_data : '0;
      if (exc_clr)     exc_q <= '0;
      else if (tail_v) exc_q <= exc_sum;
    end
  end

  assign bus.portb_rd_flag  = rd_flag_q;
  assign bus.portb_addr     = addr_q;
  assign bus.portb_wren_bus = wren_q;
  assign bus.portb_wdata    = '0;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_bin        = out_bin_q;
  assign bus.out_data       = out_data_q;
  assign bus.exc_bus        = exc_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_hist_bank_reader.sv
// Directed bench: two readers (clear-on-read on/off) against read-first RAM models, RD_LAT=2.
module tb_hist_bank_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hist_bank_reader_if ifa ();
  hist_bank_reader_if ifb ();

  hist_bank_reader #(.CLEAR_ON_READ(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  hist_bank_reader #(.CLEAR_ON_READ(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]  mem_a [32][256];
  logic [15:0]  mem_b [32][256];
  logic [511:0] ra1, ra2, rb1, rb2;
  logic         load_a, load_b;
  int           pat_a, pat_b;

  function automatic logic [15:0] pat(int p, int b, int k);
    if (p == 0) return 16'(k);
    return (b == 7) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic logic [511:0] rep16(logic [15:0] v);
    logic [511:0] r;
    for (int b = 0; b < 32; b++) r[b*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [767:0] rep24(logic [23:0] v);
    logic [767:0] r;
    for (int b = 0; b < 32; b++) r[b*24 +: 24] = v;
    return r;
  endfunction

  // Read-first RAM models with two-cycle read latency
  always @(posedge clk) begin
    if (load_a) begin
      for (int b = 0; b < 32; b++)
        for (int k = 0; k < 256; k++) mem_a[b][k] <= pat(pat_a, b, k);
    end else begin
      for (int b = 0; b < 32; b++) begin
        ra1[b*16 +: 16] <= mem_a[b][ifa.portb_addr];
        if (ifa.portb_wren_bus[b]) mem_a[b][ifa.portb_addr] <= ifa.portb_wdata;
      end
    end
    ra2 <= ra1;
  end

  always @(posedge clk) begin
    if (load_b) begin
      for (int b = 0; b < 32; b++)
        for (int k = 0; k < 256; k++) mem_b[b][k] <= pat(pat_b, b, k);
    end else begin
      for (int b = 0; b < 32; b++) begin
        rb1[b*16 +: 16] <= mem_b[b][ifb.portb_addr];
        if (ifb.portb_wren_bus[b]) mem_b[b][ifb.portb_addr] <= ifb.portb_wdata;
      end
    end
    rb2 <= rb1;
  end

  assign ifa.portb_rdata = ra2;
  assign ifb.portb_rdata = rb2;

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input int sel, input int p);
    @(negedge clk);
    if (sel == 1) begin pat_b = p; load_b = 1'b1; end
    else          begin pat_a = p; load_a = 1'b1; end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // One sweep observed over cycles 1..260; optional extra starts at cycle 50 and the done cycle
  task automatic run_sweep(input int sel, input logic [15:0] clip, input bit retrig,
                           input logic [511:0] e50, input logic [511:0] e200,
                           input logic [767:0] e_exc, input string tag);
    int first, n_valid, bin_err, exp_bin, done_cnt, done_rel, busy_cnt, rd_cnt, wren_ok;
    logic [511:0] d50, d200, data;
    logic [31:0]  exp_w, wren;
    logic         vld, dn, bsy, rdf;
    logic [7:0]   bin;
    first = -1; n_valid = 0; bin_err = 0; exp_bin = 0; done_cnt = 0; done_rel = -1;
    busy_cnt = 0; rd_cnt = 0; wren_ok = 0; d50 = 'x; d200 = 'x;
    exp_w = (sel == 1) ? 32'h0 : 32'hFFFF_FFFF;
    @(negedge clk);
    if (sel == 1) begin ifb.clip_limit = clip; ifb.start = 1'b1; end
    else          begin ifa.clip_limit = clip; ifa.start = 1'b1; end
    for (int rel = 1; rel <= 260; rel++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      if (retrig && (rel == 50 || rel == 260)) begin
        if (sel == 1) ifb.start = 1'b1; else ifa.start = 1'b1;
      end
      vld  = (sel == 1) ? ifb.out_valid      : ifa.out_valid;
      bin  = (sel == 1) ? ifb.out_bin        : ifa.out_bin;
      data = (sel == 1) ? ifb.out_data       : ifa.out_data;
      dn   = (sel == 1) ? ifb.done           : ifa.done;
      bsy  = (sel == 1) ? ifb.busy           : ifa.busy;
      rdf  = (sel == 1) ? ifb.portb_rd_flag  : ifa.portb_rd_flag;
      wren = (sel == 1) ? ifb.portb_wren_bus : ifa.portb_wren_bus;
      if (vld) begin
        if (first < 0) first = rel;
        if (int'(bin) != exp_bin) bin_err++;
        exp_bin++;
        n_valid++;
        if (bin == 8'd50)  d50  = data;
        if (bin == 8'd200) d200 = data;
      end
      if (dn) begin done_cnt++; done_rel = rel; end
      if (bsy) busy_cnt++;
      if (rdf) rd_cnt++;
      if (wren === (rdf ? exp_w : 32'h0)) wren_ok++;
    end
    chk({tag, " first_valid_cycle"}, 768'(first), 768'(4));
    chk({tag, " valid_count"},       768'(n_valid), 768'(256));
    chk({tag, " bin_sequence_errs"}, 768'(bin_err), 768'(0));
    chk({tag, " data_bin50"},        768'(d50), 768'(e50));
    chk({tag, " data_bin200"},       768'(d200), 768'(e200));
    chk({tag, " done_count"},        768'(done_cnt), 768'(1));
    chk({tag, " done_cycle"},        768'(done_rel), 768'(260));
    chk({tag, " busy_cycles"},       768'(busy_cnt), 768'(260));
    chk({tag, " rd_flag_cycles"},    768'(rd_cnt), 768'(256));
    chk({tag, " wren_ok_cycles"},    768'(wren_ok), 768'(260));
    chk({tag, " exc_bus"},           (sel == 1) ? ifb.exc_bus : ifa.exc_bus, e_exc);
  endtask

  initial begin
    logic [767:0] e7;
    int done_seen, busy_seen;
    rst_n = 1'b0;
    load_a = 1'b0; load_b = 1'b0; pat_a = 0; pat_b = 0;
    ifa.start = 1'b0; ifa.clip_limit = '0;
    ifb.start = 1'b0; ifb.clip_limit = '0;
    repeat (3) @(negedge clk);

    chk("rst busy",      768'(ifa.busy), 768'(0));
    chk("rst done",      768'(ifa.done), 768'(0));
    chk("rst out_valid", 768'(ifa.out_valid), 768'(0));
    chk("rst rd_flag",   768'(ifa.portb_rd_flag), 768'(0));
    chk("rst wren",      768'(ifa.portb_wren_bus), 768'(0));
    chk("rst out_data",  768'(ifa.out_data), 768'(0));
    chk("rst exc_bus",   ifb.exc_bus, 768'(0));
    rst_n = 1'b1;

    load_mem(0, 0);
    load_mem(1, 0);
    run_sweep(0, 16'd100, 1'b1, rep16(16'd50), rep16(16'd100), rep24(24'd12090), "A_clip100_retrig");
    run_sweep(0, 16'd0,   1'b0, rep16(16'd0),  rep16(16'd0),   rep24(24'd0),     "A_after_clear");
    run_sweep(1, 16'd100, 1'b0, rep16(16'd50), rep16(16'd100), rep24(24'd12090), "B_sweep1");
    run_sweep(1, 16'd100, 1'b0, rep16(16'd50), rep16(16'd100), rep24(24'd12090), "B_sweep2");
    run_sweep(1, 16'hFFFF, 1'b0, rep16(16'd50), rep16(16'd200), rep24(24'd0),    "B_noclip");

    load_mem(1, 1);
    e7 = '0;
    e7[7*24 +: 24] = 24'd16776960;
    run_sweep(1, 16'd0, 1'b0, rep16(16'd0), rep16(16'd0), e7, "B_bank7_full");

    // Abort a sweep with reset at cycle 120
    load_mem(0, 0);
    @(negedge clk);
    ifa.clip_limit = 16'd100;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (int r = 2; r <= 120; r++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy",      768'(ifa.busy), 768'(0));
    chk("midrst out_valid", 768'(ifa.out_valid), 768'(0));
    chk("midrst rd_flag",   768'(ifa.portb_rd_flag), 768'(0));
    chk("midrst exc_bus",   ifa.exc_bus, 768'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int r = 0; r < 300; r++) begin
      @(negedge clk);
      if (ifa.done) done_seen++;
      if (ifa.busy) busy_seen++;
    end
    chk("postrst done_seen", 768'(done_seen), 768'(0));
    chk("postrst busy_seen", 768'(busy_seen), 768'(0));
    chk("postrst bin118_cleared", 768'(mem_a[3][118]), 768'(0));
    chk("postrst bin119_kept",    768'(mem_a[3][119]), 768'(119));
    run_sweep(0, 16'd100, 1'b0, rep16(16'd0), rep16(16'd100), rep24(24'd11919), "A_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
